// File: rtl/instruction_prefetch_buffer.sv
// Instruction prefetch FIFO feeding a registered opcode/operand IR with flush and underflow flag.
// Optional per-entry even-parity checking when IR_PARITY_EN is defined.
module instruction_prefetch_buffer #(
   parameter int INSTR_WIDTH  = 8,
   parameter int OPCODE_WIDTH = 4,
   parameter int DEPTH        = 4
) (
   input  logic                                i_clock,
   input  logic                                i_reset,
   input  logic                                i_fetch_valid,
   input  logic [INSTR_WIDTH-1:0]              i_fetch_instr,
`ifdef IR_PARITY_EN
   input  logic                                i_fetch_parity,
   output logic                                o_parity_err,
`endif
   output logic                                o_fetch_ready,
   input  logic                                i_load_ir,
   input  logic                                i_flush,
   output logic [OPCODE_WIDTH-1:0]             o_opcode,
   output logic [INSTR_WIDTH-OPCODE_WIDTH-1:0] o_data_out,
   output logic                                o_ir_valid,
   output logic [$clog2(DEPTH):0]              o_count,
   output logic                                o_underflow
);

   localparam int PTR_W  = $clog2(DEPTH);
   localparam int CNT_W  = PTR_W + 1;
   localparam int DATA_W = INSTR_WIDTH - OPCODE_WIDTH;
   localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

   logic [INSTR_WIDTH-1:0]  r_mem [DEPTH];
   logic [PTR_W-1:0]        r_wr_ptr;
   logic [PTR_W-1:0]        r_rd_ptr;
   logic [CNT_W-1:0]        r_count;
   logic [OPCODE_WIDTH-1:0] r_opcode;
   logic [DATA_W-1:0]       r_data_out;
   logic                    r_ir_valid;
   logic                    r_underflow;

   logic                    w_empty;
   logic                    w_push;
   logic                    w_pop;
   logic [INSTR_WIDTH-1:0]  w_head;

   // Push and pop both look only at the pre-edge count: no bypass, no same-cycle room on full.
   assign w_empty = (r_count == '0);
   assign w_push  = i_fetch_valid && o_fetch_ready && !i_flush;
   assign w_pop   = i_load_ir && !w_empty && !i_flush;
   assign w_head  = r_mem[r_rd_ptr];

   assign o_fetch_ready = (r_count != FULL);
   assign o_count       = r_count;
   assign o_opcode      = r_opcode;
   assign o_data_out    = r_data_out;
   assign o_ir_valid    = r_ir_valid;
   assign o_underflow   = r_underflow;

   always_ff @(posedge i_clock) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= i_fetch_instr;
      end
   end

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_opcode    <= '0;
         r_data_out  <= '0;
         r_ir_valid  <= 1'b0;
         r_underflow <= 1'b0;
      end else if (i_flush) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_opcode    <= '0;
         r_data_out  <= '0;
         r_ir_valid  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         r_underflow <= i_load_ir && w_empty;
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr   <= r_rd_ptr + PTR_W'(1);
            r_opcode   <= w_head[INSTR_WIDTH-1 -: OPCODE_WIDTH];
            r_data_out <= w_head[DATA_W-1:0];
            r_ir_valid <= 1'b1;
         end else if (i_load_ir) begin
            r_ir_valid <= 1'b0;
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + CNT_W'(1);
         end else if (w_pop && !w_push) begin
            r_count <= r_count - CNT_W'(1);
         end
      end
   end

`ifdef IR_PARITY_EN
   logic r_par [DEPTH];
   logic r_parity_err;

   assign o_parity_err = r_parity_err;

   always_ff @(posedge i_clock) begin
      if (w_push) begin
         r_par[r_wr_ptr] <= i_fetch_parity;
      end
   end

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_parity_err <= 1'b0;
      end else if (i_flush) begin
         r_parity_err <= 1'b0;
      end else if (w_pop) begin
         r_parity_err <= (r_par[r_rd_ptr] != (^w_head));
      end
   end
`endif

endmodule

// File: tb/tb_instruction_prefetch_buffer.sv
// Directed plus randomized bench for instruction_prefetch_buffer against a queue-based model.
// Build with IR_PARITY_EN defined to also exercise the parity path.
module tb_instruction_prefetch_buffer;

   localparam int IW = 8;
   localparam int OW = 4;
   localparam int DEPTH = 4;

   logic          clock = 1'b0;
   logic          reset;
   logic          fetch_valid;
   logic [IW-1:0] fetch_instr;
   logic          fetch_parity;
   logic          fetch_ready;
   logic          load_ir;
   logic          flush;
   logic [OW-1:0] opcode;
   logic [IW-OW-1:0] data_out;
   logic          ir_valid;
   logic [2:0]    count;
   logic          underflow;
   logic          parity_err;

   instruction_prefetch_buffer #(.INSTR_WIDTH(IW), .OPCODE_WIDTH(OW), .DEPTH(DEPTH)) dut (
      .i_clock       (clock),
      .i_reset       (reset),
      .i_fetch_valid (fetch_valid),
      .i_fetch_instr (fetch_instr),
`ifdef IR_PARITY_EN
      .i_fetch_parity(fetch_parity),
      .o_parity_err  (parity_err),
`endif
      .o_fetch_ready (fetch_ready),
      .i_load_ir     (load_ir),
      .i_flush       (flush),
      .o_opcode      (opcode),
      .o_data_out    (data_out),
      .o_ir_valid    (ir_valid),
      .o_count       (count),
      .o_underflow   (underflow)
   );

`ifndef IR_PARITY_EN
   assign parity_err = 1'b0;
`endif

   always #5 clock = ~clock;

   int n_pass = 0;
   int n_total = 0;

   // Reference model: FIFO as a queue of words with a parallel queue of parity bits.
   logic [IW-1:0] m_q[$];
   logic          m_pq[$];
   logic [IW-1:0] m_ir;
   logic          m_valid;
   logic          m_uf;
   logic          m_perr;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic model_reset();
      m_q.delete();
      m_pq.delete();
      m_ir = '0;
      m_valid = 1'b0;
      m_uf = 1'b0;
      m_perr = 1'b0;
   endtask

   task automatic model_edge(input bit v, input logic [IW-1:0] w, input bit ld, input bit fl, input bit p);
      logic [IW-1:0] hw;
      logic          hp;
      bit            room;
      if (fl) begin
         model_reset();
         return;
      end
      room = (m_q.size() != DEPTH);
      m_uf = ld && (m_q.size() == 0);
      if (ld && m_q.size() != 0) begin
         hw = m_q.pop_front();
         hp = m_pq.pop_front();
         m_ir = hw;
         m_valid = 1'b1;
         m_perr = (hp != ^hw);
      end else if (ld) begin
         m_valid = 1'b0;
      end
      if (v && room) begin
         m_q.push_back(w);
         m_pq.push_back(p);
      end
   endtask

   task automatic compare_all(input string tag);
      chk({tag, ".count"}, 32'(count), 32'(m_q.size()));
      chk({tag, ".ready"}, 32'(fetch_ready), 32'(m_q.size() != DEPTH));
      chk({tag, ".opcode"}, 32'(opcode), 32'(m_ir[IW-1 -: OW]));
      chk({tag, ".data"}, 32'(data_out), 32'(m_ir[IW-OW-1:0]));
      chk({tag, ".ir_valid"}, 32'(ir_valid), 32'(m_valid));
      chk({tag, ".underflow"}, 32'(underflow), 32'(m_uf));
`ifdef IR_PARITY_EN
      chk({tag, ".parity_err"}, 32'(parity_err), 32'(m_perr));
`endif
   endtask

   // Called at posedge+1; applies inputs for the next edge, then checks 1 time unit after it.
   task automatic step(input string tag, input bit v, input logic [IW-1:0] w, input bit ld,
                       input bit fl, input bit p);
      fetch_valid = v;
      fetch_instr = w;
      load_ir = ld;
      flush = fl;
      fetch_parity = p;
      @(posedge clock);
      model_edge(v, w, ld, fl, p);
      #1;
      compare_all(tag);
   endtask

   task automatic push(input string tag, input logic [IW-1:0] w);
      step(tag, 1'b1, w, 1'b0, 1'b0, ^w);
   endtask

   task automatic pop(input string tag);
      step(tag, 1'b0, '0, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic idle(input string tag);
      step(tag, 1'b0, '0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      logic [IW-1:0] rw;
      bit rv, rl, rf, rp;
      reset = 1'b1;
      fetch_valid = 1'b0;
      fetch_instr = '0;
      fetch_parity = 1'b0;
      load_ir = 1'b0;
      flush = 1'b0;
      model_reset();
      #12;
      compare_all("por");
      reset = 1'b0;
      @(posedge clock);
      #1;

      // Reset mid-stream
      push("rst_p0", 8'h12);
      push("rst_p1", 8'h34);
      push("rst_p2", 8'h56);
      pop("rst_pop");
      #3 reset = 1'b1;
      #1;
      model_reset();
      compare_all("rst_async");
      chk("rst_ready_const", 32'(fetch_ready), 32'd1);
      #2 reset = 1'b0;
      pop("rst_uf");
      chk("rst_uf_const", 32'(underflow), 32'd1);

      // Ordering
      push("ord_p0", 8'hA5);
      push("ord_p1", 8'h3C);
      pop("ord_pop0");
      chk("ord_op0", 32'(opcode), 32'hA);
      chk("ord_d0", 32'(data_out), 32'h5);
      chk("ord_cnt0", 32'(count), 32'd1);
      pop("ord_pop1");
      chk("ord_op1", 32'(opcode), 32'h3);
      chk("ord_d1", 32'(data_out), 32'hC);
      chk("ord_cnt1", 32'(count), 32'd0);

      // Full and wrap-around
      push("full_p0", 8'h11);
      push("full_p1", 8'h22);
      push("full_p2", 8'h33);
      push("full_p3", 8'h44);
      chk("full_ready", 32'(fetch_ready), 32'd0);
      step("full_p4", 1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
      chk("full_no_accept", 32'(count), 32'd4);
      step("full_pop_v", 1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
      chk("full_pop_no_room", 32'(count), 32'd3);
      push("wrap_p77", 8'h77);
      pop("wrap_q0");
      pop("wrap_q1");
      pop("wrap_q2");
      pop("wrap_q3");
      chk("wrap_op", 32'(opcode), 32'h7);
      chk("wrap_d", 32'(data_out), 32'h7);

      // Simultaneous push and pop
      push("sim_p0", 8'hB1);
      push("sim_p1", 8'hC2);
      step("sim_pp", 1'b1, 8'hD3, 1'b1, 1'b0, ^8'hD3);
      chk("sim_cnt", 32'(count), 32'd2);
      chk("sim_op", 32'(opcode), 32'hB);
      pop("sim_drain0");
      pop("sim_drain1");

      // Empty pop, then flush
      pop("emp_pop");
      chk("emp_uf", 32'(underflow), 32'd1);
      chk("emp_irv", 32'(ir_valid), 32'd0);
      chk("emp_hold", 32'(opcode), 32'hD);
      idle("emp_idle");
      chk("emp_uf_clr", 32'(underflow), 32'd0);
      push("fl_p0", 8'h9A);
      push("fl_p1", 8'h8B);
      push("fl_p2", 8'h7C);
      step("fl_flush", 1'b1, 8'hEE, 1'b1, 1'b1, 1'b0);
      chk("fl_cnt", 32'(count), 32'd0);
      chk("fl_op", 32'(opcode), 32'h0);
      pop("fl_after");

`ifdef IR_PARITY_EN
      step("par_bad", 1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
      pop("par_bad_pop");
      chk("par_err_set", 32'(parity_err), 32'd1);
      push("par_good", 8'h03);
      pop("par_good_pop");
      chk("par_err_clr", 32'(parity_err), 32'd0);
`endif

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         rv = ($urandom_range(0, 99) < 60);
         rl = ($urandom_range(0, 99) < 45);
         rf = ($urandom_range(0, 99) < 3);
         rw = IW'($urandom);
         rp = (^rw) ^ ($urandom_range(0, 7) == 0);
         step("rnd", rv, rw, rl, rf, rp);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/instruction_prefetch_buffer.md
# instruction_prefetch_buffer

Parametrised successor to the 8-bit instruction register. It accepts fetched instruction words from program memory into a DEPTH-entry FIFO through a valid/ready handshake. When the controller asserts LoadIR, it pops the oldest word and splits it into registered opcode and operand fields. The block sits between the memory fetch path and the controller/decoder, so fetch can run ahead of execution, and it provides a flush for branches.

## Interface
- INSTR_WIDTH, 8: instruction word width.
- OPCODE_WIDTH, 4: opcode field width, taken from the MSBs; must be < INSTR_WIDTH.
- DEPTH, 4: queue entries; power of two, ≥ 2.
- clock  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- fetch_valid  input  1  fetch_instr holds a word.
- fetch_instr  input  INSTR_WIDTH  fetched instruction word.
- fetch_ready  output  1  queue can accept a word; equals (count != DEPTH).
- LoadIR  input  1  pop the head word into the IR outputs.
- flush  input  1  discard the queued words and the IR contents.
- opcode  output  OPCODE_WIDTH  instruction[INSTR_WIDTH-1 -: OPCODE_WIDTH] of the popped word.
- data_out  output  INSTR_WIDTH-OPCODE_WIDTH  remaining low bits of the popped word.
- ir_valid  output  1  opcode/data_out hold a word popped by the last LoadIR.
- count  output  $clog2(DEPTH)+1  queued words, range 0..DEPTH.
- underflow  output  1  one-cycle pulse: LoadIR arrived while the queue was empty.

## Operation
- Reset values: opcode 0, data_out 0 (NOP), ir_valid 0, count 0, underflow 0, rd/wr pointers 0. fetch_ready is therefore 1 during reset.
- Push: on an edge where fetch_valid && fetch_ready, write fetch_instr at wr_ptr and increment wr_ptr modulo DEPTH.
- Pop: on an edge where LoadIR && count != 0:
  - opcode and data_out take the head word;
  - rd_ptr increments modulo DEPTH;
  - ir_valid is set to 1.
- LoadIR with count == 0:
  - opcode and data_out hold their values;
  - ir_valid is cleared to 0;
  - underflow is 1 for exactly the next cycle.
- No LoadIR: opcode, data_out and ir_valid hold. underflow is 0 in every cycle not caused by an empty LoadIR.
- count arithmetic:
  - push only: +1;
  - pop only: −1;
  - push and pop on the same edge: count is unchanged and both pointers advance.
- Full queue: fetch_ready is 0, so no push occurs even if fetch_valid is high. A pop on the same edge does not make room that cycle. fetch_ready rises one cycle later.
- No bypass: a word pushed on edge N is poppable from edge N+1 onwards. LoadIR on edge N into an empty queue underflows, even if a push happens on edge N.
- flush has highest priority. On an edge with flush = 1:
  - count and both pointers go to 0;
  - opcode and data_out go to 0;
  - ir_valid and underflow go to 0;
  - any simultaneous push or pop is ignored.
- Pointer wrap: pointers are $clog2(DEPTH) bits wide and wrap naturally. count alone distinguishes full from empty.

## Timing
- The IR fields have 1-cycle latency from the LoadIR edge.
- fetch_ready is combinational from the count register only; there is no path from fetch_valid or LoadIR.
- All other outputs are registered.
- Reset asserted mid-operation immediately forces every output to its reset value, asynchronously. Queue contents are discarded.
- Storage RAM is not reset; it is unread until it has been written.

## Configuration
- IR_PARITY_EN defined:
  - adds input fetch_parity (1 bit, even parity over fetch_instr), stored per entry;
  - adds registered output parity_err;
  - parity_err is set on a pop whose stored parity ≠ ^word, and cleared on any non-faulting pop, flush or reset.
- IR_PARITY_EN undefined: neither port nor the per-entry parity storage exists. Behaviour is otherwise identical.

## Test plan
- Reset mid-stream:
  - stimulus: push 3 words, then pulse reset.
  - required: count=0, opcode=0, data_out=0, ir_valid=0, fetch_ready=1; the next LoadIR underflows.
- Ordering with defaults:
  - stimulus: push 8'hA5, 8'h3C, then LoadIR twice.
  - required: opcode=4'hA/data_out=4'h5, then 4'h3/4'hC; ir_valid=1; count 2→1→0.
- Full and wrap:
  - stimulus: push 4 words; fetch_valid stays high.
  - required: fetch_ready=0 and the 5th word is not accepted.
  - stimulus continued: pop 1, then push 8'h77, then pop 4.
  - required: the last pop yields 4'h7/4'h7 (wrap-around is correct).
- Simultaneous push and pop:
  - stimulus: count=2, push and LoadIR on the same edge.
  - required: count stays 2; the popped value is the oldest entry.
- Empty pop and flush:
  - stimulus: LoadIR on an empty queue.
  - required: underflow=1 for 1 cycle, ir_valid=0, IR holds its old value.
  - stimulus: flush with count=3, concurrent with push and LoadIR.
  - required: count=0, opcode=0, no push accepted.
- With IR_PARITY_EN defined:
  - stimulus: push 8'h01 with fetch_parity=0, then pop.
  - required: parity_err=1; it clears on the next good pop.
